uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- 8N1 UART receiver feeding a first-word-fall-through FIFO.
//
// The serial line passes through a two-flop synchronizer (idle high). A
// five-state receiver (IDLE, START, DATA, STOP, WAIT_HIGH) samples the
// start bit at mid-bit, then samples eight data bits and the stop bit one
// bit time apart. Each good byte is pushed into the FIFO. A bad stop bit
// pulses frame_err once, and the receiver then waits for the line to return
// high, so a break condition reports only once.
//
// Optional build macro UART_RX_MAJORITY_EN: each sample becomes the 2-of-3
// majority of the synchronized line at target-1, target and target+1. The
// decision is taken at target+1. Sample centres and bit spacing stay the same.
//
// Ports:
//   clock        in   sole clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   uart_rx      in   asynchronous serial line, idle high, LSB first
//   rx_data      out  FIFO head byte (holds last value while empty)
//   rx_valid     out  FIFO non-empty
//   rx_ready     in   consumer accepts head byte (pop = rx_valid & rx_ready)
//   frame_err    out  one-cycle pulse on a bad stop bit
//   overrun      out  one-cycle pulse when a good byte is dropped (FIFO full)
//   fifo_count   out  current FIFO occupancy
//   dbg_state_o  out  receiver state: 0 IDLE, 1 START, 2 DATA, 3 STOP, 4 WAIT_HIGH
//
// Handshake: the head byte is transferred on every rising clock edge where
// rx_valid and rx_ready are both high. rx_ready has no effect while
// rx_valid is low.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 10000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          uart_rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [2:0]                    dbg_state_o
);

    localparam int BIT_CYCLES = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF       = BIT_CYCLES / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int DLY = 1;
`else
    localparam int DLY = 0;
`endif
    localparam int CNT_W = $clog2(BIT_CYCLES + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);

    // With majority voting, the decision comes one count late. The counter
    // then restarts at 1, so the next sample centre is still BIT_CYCLES away.
    localparam logic [CNT_W-1:0] START_TGT  = CNT_W'(HALF - 1 + DLY);
    localparam logic [CNT_W-1:0] BIT_TGT    = CNT_W'(BIT_CYCLES - 1 + DLY);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DLY);
    localparam logic [AW:0]      FULL_CNT   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             sync1_q, sync2_q;
    logic             rxs, sample_bit;
    logic             push_req, ferr_d, ferr_q, ovr_d, ovr_q;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      count_q, count_d;
    logic [7:0]       rx_data_q, rx_data_d, head_d;
    logic             pop, full, push_ok;

    assign rxs = sync2_q;

`ifdef UART_RX_MAJORITY_EN
    // hist_q[1] and hist_q[0] hold rxs from two cycles ago and one cycle ago.
    logic [1:0] hist_q;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) hist_q <= 2'b11;
        else          hist_q <= {hist_q[0], rxs};
    end
    assign sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
    assign sample_bit = rxs;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push_req = 1'b0;
        ferr_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == START_TGT) begin
                    if (sample_bit) begin
                        state_d = S_IDLE;   // glitch shorter than half a bit
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = CNT_RELOAD;
                        bit_d   = '0;
                    end
                end
            end
            S_DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == BIT_TGT) begin
                    cnt_d   = CNT_RELOAD;
                    shift_d = {sample_bit, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == BIT_TGT) begin
                    cnt_d = CNT_RELOAD;
                    if (sample_bit) begin
                        push_req = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO: pointers wrap naturally because FIFO_DEPTH is a power of two.
    assign pop     = (count_q != '0) & rx_ready;
    assign full    = (count_q == FULL_CNT);
    assign push_ok = push_req & (~full | pop);
    assign ovr_d   = push_req & full & ~pop;
    assign wr_d    = wr_q + AW'(push_ok);
    assign rd_d    = rd_q + AW'(pop);
    assign count_d = count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop);

    // The registered head must see a byte written this edge when the new
    // read pointer lands on the slot being written.
    always_comb begin
        head_d = mem[rd_d];
        if (push_ok && (rd_d == wr_q)) head_d = shift_q;
        rx_data_d = (count_d != '0) ? head_d : rx_data_q;
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_q] <= shift_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            rx_data_q <= 8'h00;
            ovr_q     <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            rx_data_q <= rx_data_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = (count_q != '0);
    assign fifo_count  = count_q;
    assign frame_err   = ferr_q;
    assign overrun     = ovr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed/randomized bench for uart_rx_fifo at default parameters.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int BIT   = 87;          // clocks per bit at 10 MHz / 115200
    localparam int HALF  = BIT / 2;
    localparam int DEPTH = 8;
`ifdef UART_RX_MAJORITY_EN
    localparam int DLY = 1;
`else
    localparam int DLY = 0;
`endif
    // Edge (counted from the start-bit drive) of the stop-bit decision:
    // 2 synchronizer edges + 1 edge to leave IDLE, half a bit, nine bits.
    localparam int STOP_EDGE = 3 + HALF + 9 * BIT + DLY;
    localparam logic [2:0] IDLE_CODE = 3'd0;

    logic       clock, reset_n, uart_rx, rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun;
    logic [3:0] fifo_count;
    logic [2:0] dbg_state;

    uart_rx_fifo dut (
        .clock(clock), .reset_n(reset_n), .uart_rx(uart_rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overrun(overrun), .fifo_count(fifo_count),
        .dbg_state_o(dbg_state)
    );

    initial clock = 1'b0;
    always #50 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int fe_cnt = 0, ov_cnt = 0;
    int fe_exp = 0, ov_exp = 0, occ = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    // Monitor: collect pulses and popped bytes on the falling edge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame; the line is left at the stop-bit value.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(posedge clock); #1 uart_rx = 1'b0;
        repeat (BIT) @(posedge clock);
        for (int i = 0; i < 8; i++) begin
            #1 uart_rx = b[i];
            repeat (BIT) @(posedge clock);
        end
        #1 uart_rx = stop_bit;
        repeat (BIT) @(posedge clock);
    endtask

    // Reference model: a good byte is delivered unless the consumer is
    // stalled and the FIFO already holds DEPTH bytes.
    task automatic model_frame(input logic [7:0] b, input logic good);
        if (!good) fe_exp++;
        else if (rx_ready || occ < DEPTH) begin
            exp_q.push_back(b);
            if (!rx_ready) occ++;
        end else ov_exp++;
    endtask

    task automatic check_delivery(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic drain();
        @(posedge clock); #1 rx_ready = 1'b1;
        repeat (DEPTH + 2) @(posedge clock);
        #1 rx_ready = 1'b0;
        occ = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] b;
        uart_rx = 1'b1; rx_ready = 1'b0; reset_n = 1'b0;
        #20;
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE_CODE));
        wait_cycles(3); reset_n = 1'b1;
        wait_cycles(5);

        // rx_ready while empty does nothing
        rx_ready = 1'b1;
        wait_cycles(4);
        check("empty_ready_count", 32'(fifo_count), 32'd0);
        check("empty_ready_valid", 32'(rx_valid), 32'd0);

        // single 0x55 with consumer ready
        send_frame(8'h55, 1'b1); model_frame(8'h55, 1'b1);
        wait_cycles(3);
        check_delivery("byte55");
        check("byte55_ferr", 32'(fe_cnt), 32'(fe_exp));
        check("byte55_ovr", 32'(ov_cnt), 32'(ov_exp));
        check("byte55_hold", 32'(rx_data), 32'h55);
        check("byte55_empty", 32'(rx_valid), 32'd0);

        // random bytes with consumer ready
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(255, 0));
            send_frame(b, 1'b1); model_frame(b, 1'b1);
        end
        wait_cycles(3);
        check_delivery("rand_ready");

        // nine bytes into a stalled FIFO
        rx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            send_frame(8'(i), 1'b1); model_frame(8'(i), 1'b1);
        end
        wait_cycles(3);
        check("fill_count", 32'(fifo_count), 32'(occ));
        check("fill_ovr", 32'(ov_cnt), 32'(ov_exp));
        check("fill_valid", 32'(rx_valid), 32'd1);
        check("fill_head", 32'(rx_data), 32'(exp_q[0]));
        drain();
        wait_cycles(2);
        check("drain_count", 32'(fifo_count), 32'd0);
        check_delivery("fill_drain");
        check("drain_hold", 32'(rx_data), 32'h07);

        // bad stop bit followed by a break of three bit times
        rx_ready = 1'b1;
        send_frame(8'hA3, 1'b0); model_frame(8'hA3, 1'b0);
        repeat (3 * BIT) @(posedge clock);
        #1 uart_rx = 1'b1;
        wait_cycles(2 * BIT);
        check("break_ferr", 32'(fe_cnt), 32'(fe_exp));
        check("break_state", 32'(dbg_state), 32'(IDLE_CODE));
        send_frame(8'h3C, 1'b1); model_frame(8'h3C, 1'b1);
        wait_cycles(3);
        check_delivery("after_break");
        check("after_break_ferr", 32'(fe_cnt), 32'(fe_exp));

        // short low glitch on idle line
        @(posedge clock); #1 uart_rx = 1'b0;
        repeat (20) @(posedge clock);
        #1 uart_rx = 1'b1;
        wait_cycles(BIT);
        check("glitch_valid", 32'(rx_valid), 32'd0);
        check("glitch_ferr", 32'(fe_cnt), 32'(fe_exp));
        check("glitch_state", 32'(dbg_state), 32'(IDLE_CODE));
        check_delivery("glitch");

        // full FIFO, one pop exactly at the stop decision of 0x7E
        rx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom_range(255, 0));
            send_frame(b, 1'b1); model_frame(b, 1'b1);
        end
        wait_cycles(2);
        check("full_count", 32'(fifo_count), 32'(DEPTH));
        fork
            send_frame(8'h7E, 1'b1);
            begin
                @(posedge clock); #1;
                repeat (STOP_EDGE - 1) @(posedge clock);
                #1 rx_ready = 1'b1;
                @(posedge clock);
                #1 rx_ready = 1'b0;
            end
        join
        exp_q.push_back(8'h7E);   // head popped, 0x7E lands at the tail
        wait_cycles(2);
        check("simul_count", 32'(fifo_count), 32'(DEPTH));
        check("simul_ovr", 32'(ov_cnt), 32'(ov_exp));
        check("simul_pop", 32'(got_q.size()), 32'd1);
        drain();
        wait_cycles(2);
        check_delivery("simul_drain");
        check("simul_last", 32'(rx_data), 32'h7E);

        // reset in the middle of a frame
        b = 8'($urandom_range(255, 0));
        send_frame(b, 1'b1); model_frame(b, 1'b1);
        wait_cycles(2);
        check("prereset_count", 32'(fifo_count), 32'd1);
        b = {4'hF, 4'($urandom_range(15, 0))};
        fork
            send_frame(b, 1'b1);
            begin
                @(posedge clock); #1;
                repeat (5 * BIT + HALF) @(posedge clock);
                #1 reset_n = 1'b0;
                #10;
                check("midrst_count", 32'(fifo_count), 32'd0);
                check("midrst_valid", 32'(rx_valid), 32'd0);
                check("midrst_data", 32'(rx_data), 32'h00);
                check("midrst_state", 32'(dbg_state), 32'(IDLE_CODE));
                wait_cycles(5);
                reset_n = 1'b1;
            end
        join
        exp_q.delete(); got_q.delete(); occ = 0;
        wait_cycles(BIT);
        check("postrst_valid", 32'(rx_valid), 32'd0);
        rx_ready = 1'b1;
        send_frame(8'h81, 1'b1); model_frame(8'h81, 1'b1);
        wait_cycles(3);
        check_delivery("postrst");
        check("final_ferr", 32'(fe_cnt), 32'(fe_exp));
        check("final_ovr", 32'(ov_cnt), 32'(ov_exp));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
